// File: rtl/biquad_coef_fetch.sv
// Fetches one biquad section's five signed coefficients over a read-only
// Wishbone master in two 64-bit beats and presents them as a single atomic update.
module biquad_coef_fetch (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic [7:0]         section_i,
  output logic               busy_o,
  output logic               coef_valid_o,
  output logic               err_o,
  output logic signed [15:0] b0_o,
  output logic signed [15:0] b1_o,
  output logic signed [15:0] b2_o,
  output logic signed [15:0] a1_o,
  output logic signed [15:0] a2_o,
  output logic               biquad_wb_cyc_o,
  output logic               biquad_wb_stb_o,
  output logic [8:0]         biquad_wb_adr_o,
  input  logic [63:0]        biquad_wb_dat_i,
  input  logic               biquad_wb_ack_i
);

  typedef enum logic [2:0] {IDLE, REQ0, GAP, REQ1, DONE, ERR} state_t;

  state_t             state_reg;
  logic [7:0]         section_reg;
  logic [3:0]         wait_cnt_reg;
  logic               busy_reg;
  logic               coef_valid_reg;
  logic               err_reg;
  logic               cyc_reg;
  logic               stb_reg;
  logic [8:0]         adr_reg;
  logic signed [15:0] hold_b0_reg, hold_b1_reg, hold_b2_reg, hold_a1_reg, hold_a2_reg;
  logic signed [15:0] b0_reg, b1_reg, b2_reg, a1_reg, a2_reg;
  logic [15:0]        lane [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = biquad_wb_dat_i[16*gi +: 16];
    end
  endgenerate

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg      <= IDLE;
      section_reg    <= 8'd0;
      wait_cnt_reg   <= 4'd0;
      busy_reg       <= 1'b0;
      coef_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      cyc_reg        <= 1'b0;
      stb_reg        <= 1'b0;
      adr_reg        <= 9'd0;
      hold_b0_reg    <= 16'sd0;
      hold_b1_reg    <= 16'sd0;
      hold_b2_reg    <= 16'sd0;
      hold_a1_reg    <= 16'sd0;
      hold_a2_reg    <= 16'sd0;
      b0_reg         <= 16'sd0;
      b1_reg         <= 16'sd0;
      b2_reg         <= 16'sd0;
      a1_reg         <= 16'sd0;
      a2_reg         <= 16'sd0;
    end else begin
      coef_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            section_reg  <= section_i;
            wait_cnt_reg <= 4'd0;
            busy_reg     <= 1'b1;
            cyc_reg      <= 1'b1;
            stb_reg      <= 1'b1;
            adr_reg      <= {section_i, 1'b0};
            state_reg    <= REQ0;
          end
        end
        REQ0, REQ1: begin
          if (biquad_wb_ack_i) begin
            cyc_reg <= 1'b0;
            stb_reg <= 1'b0;
            adr_reg <= 9'd0;
            if (state_reg == REQ0) begin
              hold_b0_reg <= lane[0];
              hold_b1_reg <= lane[1];
              hold_b2_reg <= lane[2];
              hold_a1_reg <= lane[3];
              state_reg   <= GAP;
            end else begin
              hold_a2_reg <= lane[0];
              state_reg   <= DONE;
            end
          end else if (wait_cnt_reg == 4'd14) begin
            // This ack-less cycle brings the counter to 15: give up.
            wait_cnt_reg <= 4'd15;
            cyc_reg      <= 1'b0;
            stb_reg      <= 1'b0;
            adr_reg      <= 9'd0;
            state_reg    <= ERR;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        GAP: begin
          wait_cnt_reg <= 4'd0;
          cyc_reg      <= 1'b1;
          stb_reg      <= 1'b1;
          adr_reg      <= {section_reg, 1'b1};
          state_reg    <= REQ1;
        end
        DONE: begin
          b0_reg         <= hold_b0_reg;
          b1_reg         <= hold_b1_reg;
          b2_reg         <= hold_b2_reg;
          a1_reg         <= hold_a1_reg;
          a2_reg         <= hold_a2_reg;
          coef_valid_reg <= 1'b1;
          busy_reg       <= 1'b0;
          state_reg      <= IDLE;
        end
        ERR: begin
          err_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          cyc_reg   <= 1'b0;
          stb_reg   <= 1'b0;
          adr_reg   <= 9'd0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy_o          = busy_reg;
  assign coef_valid_o    = coef_valid_reg;
  assign err_o           = err_reg;
  assign b0_o            = b0_reg;
  assign b1_o            = b1_reg;
  assign b2_o            = b2_reg;
  assign a1_o            = a1_reg;
  assign a2_o            = a2_reg;
  assign biquad_wb_cyc_o = cyc_reg;
  assign biquad_wb_stb_o = stb_reg;
  assign biquad_wb_adr_o = adr_reg;

endmodule

// File: tb/tb_biquad_coef_fetch.sv
// Directed bench for biquad_coef_fetch: a coefficient RAM slave with programmable
// ack latency, and queues of expected beat addresses and coefficient sets.
module tb_biquad_coef_fetch;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         section = 8'd0;
  logic               busy, coef_valid, err;
  logic signed [15:0] b0, b1, b2, a1, a2;
  logic               cyc, stb;
  logic [8:0]         adr;
  logic [63:0]        dat = 64'd0;
  logic               ack = 1'b0;

  logic [63:0] mem [0:511];
  int          lat = 1;
  bit          block_b1 = 1'b0;
  int          slv_cnt = 0;

  int checks = 0;
  int failures = 0;

  logic [8:0]  adr_q [$];
  logic [79:0] coef_q [$];
  logic [79:0] last_set = 80'd0;

  biquad_coef_fetch dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .start_i         (start),
    .section_i       (section),
    .busy_o          (busy),
    .coef_valid_o    (coef_valid),
    .err_o           (err),
    .b0_o            (b0),
    .b1_o            (b1),
    .b2_o            (b2),
    .a1_o            (a1),
    .a2_o            (a2),
    .biquad_wb_cyc_o (cyc),
    .biquad_wb_stb_o (stb),
    .biquad_wb_adr_o (adr),
    .biquad_wb_dat_i (dat),
    .biquad_wb_ack_i (ack)
  );

  always #5 clk = ~clk;

  // Slave: acks the lat-th edge that sees a strobe; optionally never acks beat 1.
  always @(posedge clk) begin
    if (rst) begin
      ack     <= 1'b0;
      slv_cnt <= 0;
    end else if (stb && !ack && !(block_b1 && adr[0])) begin
      if (slv_cnt == lat - 1) begin
        ack     <= 1'b1;
        dat     <= mem[adr];
        slv_cnt <= 0;
      end else begin
        slv_cnt <= slv_cnt + 1;
      end
    end else begin
      ack <= 1'b0;
      if (!stb) slv_cnt <= 0;
    end
  end

  function automatic logic [79:0] expect_set(input logic [7:0] s);
    logic [63:0] w0;
    logic [63:0] w1;
    w0 = mem[{s, 1'b0}];
    w1 = mem[{s, 1'b1}];
    return {w0[15:0], w0[31:16], w0[47:32], w0[63:48], w1[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int ncyc);
    int cyc_hi = 0;
    int cv_hi = 0;
    int err_hi = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (cyc) cyc_hi++;
      if (coef_valid) cv_hi++;
      if (err) err_hi++;
    end
    chk({tag, "_no_cyc"}, cyc_hi, 0);
    chk({tag, "_no_valid"}, cv_hi, 0);
    chk({tag, "_no_err"}, err_hi, 0);
  endtask

  task automatic fetch(input string tag, input logic [7:0] sec, input int exp_lat,
                       input bit exp_err, input bit poke);
    int n = 0;
    int beats = 0;
    int gap_lo = 0;
    int b1_hi = 0;
    bit prev_stb = 1'b0;
    bit poked = 1'b0;
    bit fin = 1'b0;
    logic [79:0] exp_set;
    @(negedge clk);
    start   = 1'b1;
    section = sec;
    adr_q.push_back({sec, 1'b0});
    adr_q.push_back({sec, 1'b1});
    if (!exp_err) coef_q.push_back(expect_set(sec));
    @(negedge clk);
    start   = 1'b0;
    section = 8'd0;
    chk({tag, "_busy"}, busy, 1);
    while (!fin && n < 60) begin
      if (stb && !prev_stb) begin
        beats++;
        chk({tag, "_cyc_with_stb"}, cyc, 1);
        if (adr_q.size() > 0) chk({tag, "_adr"}, adr, adr_q.pop_front());
        else chk({tag, "_adr_unexpected"}, adr, 9'h1FF ^ adr);
      end
      if (beats == 1 && !stb) gap_lo++;
      if (beats == 2 && stb) b1_hi++;
      if (poke && !poked && beats == 2 && stb) begin
        start   = 1'b1;
        section = 8'd9;
        poked   = 1'b1;
      end else begin
        start   = 1'b0;
      end
      if (coef_valid) begin
        fin = 1'b1;
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_valid_expected"}, exp_err, 0);
        chk({tag, "_busy_after"}, busy, 0);
        if (coef_q.size() > 0) begin
          exp_set = coef_q.pop_front();
          chk({tag, "_coefs"}, {b0, b1, b2, a1, a2}, exp_set);
          last_set = exp_set;
        end else begin
          chk({tag, "_coef_q_empty"}, coef_q.size(), 1);
        end
      end
      if (err) begin
        fin = 1'b1;
        chk({tag, "_err_expected"}, exp_err, 1);
        chk({tag, "_err_latency"}, n, exp_lat);
        chk({tag, "_wait_cycles"}, b1_hi, 15);
        chk({tag, "_no_valid_on_err"}, coef_valid, 0);
        chk({tag, "_cyc_dropped"}, {cyc, stb}, 2'b00);
        chk({tag, "_coefs_held"}, {b0, b1, b2, a1, a2}, last_set);
      end
      prev_stb = stb;
      if (!fin) begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    chk({tag, "_completed"}, fin, 1);
    chk({tag, "_gap_cycles"}, gap_lo, 1);
    chk({tag, "_adr_q_drained"}, adr_q.size(), 0);
    chk_idle(tag, 20);
    chk({tag, "_coefs_stable"}, {b0, b1, b2, a1, a2}, last_set);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++)
      mem[i] = {16'(i * 4 + 16'h4003), 16'(i * 4 + 16'h3002), 16'(i * 4 + 16'h2001), 16'(i * 4 + 16'h1000)};
    mem[6]   = 64'h0004_0003_0002_0001;
    mem[7]   = 64'hAAAA_BBBB_CCCC_0005;
    mem[510] = {4{16'h8000}};
    mem[511] = 64'h1234_5678_9ABC_8000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {coef_valid, err}, 2'b00);
    chk("rst_bus", {cyc, stb, adr}, 11'd0);
    chk("rst_coefs", {b0, b1, b2, a1, a2}, 80'd0);
    rst = 1'b0;
    chk_idle("idle_after_rst", 5);

    // Section 3, one-cycle slave
    lat = 1;
    fetch("sec3", 8'd3, 6, 1'b0, 1'b0);
    chk("sec3_values", {b0, b1, b2, a1, a2}, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5});

    // Section 255: top addresses, negative values
    fetch("sec255", 8'd255, 6, 1'b0, 1'b0);
    chk("sec255_values", {b0, b1, b2, a1, a2}, {5{16'h8000}});
    chk("sec255_negative", $signed(a2) < 0, 1);

    // start pulsed during REQ1 is ignored
    fetch("poke", 8'd3, 6, 1'b0, 1'b1);
    chk("poke_values", {b0, b1, b2, a1, a2}, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5});

    // Beat 1 never acked
    block_b1 = 1'b1;
    fetch("tmo", 8'd5, 19, 1'b1, 1'b0);
    block_b1 = 1'b0;

    // Reset asserted in GAP
    @(negedge clk);
    start   = 1'b1;
    section = 8'd5;
    @(negedge clk);
    start   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("gap_stb_low", {cyc, stb}, 2'b00);
    chk("gap_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_flags", {coef_valid, err}, 2'b00);
    chk("async_rst_bus", {cyc, stb, adr}, 11'd0);
    chk("async_rst_coefs", {b0, b1, b2, a1, a2}, 80'd0);
    last_set = 80'd0;
    repeat (2) @(negedge clk);
    chk("rst_hold_busy", busy, 0);
    rst = 1'b0;
    chk_idle("after_abort", 5);
    fetch("post_rst", 8'd5, 6, 1'b0, 1'b0);

    // Three-cycle slave
    lat = 3;
    fetch("lat3", 8'd10, 10, 1'b0, 1'b0);

    chk("coef_q_drained", coef_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
